// File: rtl/rv_if_fetch_queue.sv
// Instruction-fetch front end: sequential PC requests, in-order variable-latency responses,
// DEPTH-entry fetch queue towards ID. Optional same-cycle response bypass: RV_IFQ_BYPASS_EN.
module rv_if_fetch_queue #(
    parameter int              XLEN    = 32,
    parameter int              DEPTH   = 4,
    parameter logic [XLEN-1:0] INIT_PC = {XLEN{1'b0}}
) (
    input  logic                       i_ifq_clk,
    input  logic                       i_ifq_rst,
    input  logic                       i_ifq_redirect,
    input  logic [XLEN-1:0]            i_ifq_redirect_pc,
    output logic                       o_ifq_imem_req_valid,
    output logic [XLEN-1:0]            o_ifq_imem_req_addr,
    input  logic                       i_ifq_imem_req_ready,
    input  logic                       i_ifq_imem_rsp_valid,
    input  logic [31:0]                i_ifq_imem_rsp_data,
    output logic                       o_ifq_id_valid,
    output logic [XLEN-1:0]            o_ifq_id_pc,
    output logic [31:0]                o_ifq_id_instr,
    input  logic                       i_ifq_id_ready,
    output logic [$clog2(DEPTH):0]     o_ifq_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [PW:0]     DEPTH_C = (PW+1)'(DEPTH);
    localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   fptr_q, fptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [PW-1:0]   drop_q, drop_d;
    logic [XLEN-1:0] pc_q    [DEPTH];
    logic [31:0]     instr_q [DEPTH];

    logic [PW-1:0]   count_s;
    logic [PW-1:0]   inflight_s;
    logic [PW:0]     occ_s;
    logic            req_valid_s;
    logic            req_fire_s;
    logic            rsp_drop_s;
    logic            rsp_fill_s;
    logic            id_valid_s;
    logic            consume_s;
    logic            bypass_s;
    logic [XLEN-1:0] id_pc_s;
    logic [31:0]     id_instr_s;

    // Handshake qualification and ID-side presentation.
    always_comb begin
        count_s     = wptr_q - rptr_q;
        inflight_s  = wptr_q - fptr_q;
        occ_s       = {1'b0, count_s} + {1'b0, drop_q};
        req_valid_s = !i_ifq_redirect && (occ_s < DEPTH_C);
        req_fire_s  = req_valid_s && i_ifq_imem_req_ready;
        // Responses with nothing outstanding match neither term and are ignored.
        rsp_drop_s  = i_ifq_imem_rsp_valid && (drop_q != {PW{1'b0}});
        rsp_fill_s  = i_ifq_imem_rsp_valid && (drop_q == {PW{1'b0}}) && (wptr_q != fptr_q);
`ifdef RV_IFQ_BYPASS_EN
        bypass_s    = rsp_fill_s && (rptr_q == fptr_q);
`else
        bypass_s    = 1'b0;
`endif
        id_valid_s  = !i_ifq_redirect && ((rptr_q != fptr_q) || bypass_s);
        consume_s   = id_valid_s && i_ifq_id_ready;
        id_pc_s     = pc_q[rptr_q[AW-1:0]];
        if (bypass_s) begin
            id_instr_s = i_ifq_imem_rsp_data;
        end else begin
            id_instr_s = instr_q[rptr_q[AW-1:0]];
        end
    end

    // Next-state for pointers, fetch PC and the count of responses still to be discarded.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        wptr_d     = wptr_q;
        fptr_d     = fptr_q;
        rptr_d     = rptr_q;
        drop_d     = drop_q;
        if (i_ifq_redirect) begin
            wptr_d     = {PW{1'b0}};
            fptr_d     = {PW{1'b0}};
            rptr_d     = {PW{1'b0}};
            fetch_pc_d = i_ifq_redirect_pc;
            // Every unfilled request becomes a drop, except one being answered right now.
            drop_d     = drop_q + inflight_s - {{AW{1'b0}}, (rsp_drop_s || rsp_fill_s)};
        end else begin
            if (req_fire_s) begin
                wptr_d     = wptr_q + PTR_ONE;
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end else begin
                wptr_d     = wptr_q;
            end
            if (rsp_drop_s) begin
                drop_d = drop_q - PTR_ONE;
            end else if (rsp_fill_s) begin
                fptr_d = fptr_q + PTR_ONE;
            end else begin
                drop_d = drop_q;
            end
            if (consume_s) begin
                rptr_d = rptr_q + PTR_ONE;
            end else begin
                rptr_d = rptr_q;
            end
        end
    end

    // State registers and entry storage.
    always_ff @(posedge i_ifq_clk) begin
        if (i_ifq_rst) begin
            fetch_pc_q <= INIT_PC;
            wptr_q     <= {PW{1'b0}};
            fptr_q     <= {PW{1'b0}};
            rptr_q     <= {PW{1'b0}};
            drop_q     <= {PW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= {XLEN{1'b0}};
                instr_q[i] <= 32'h0000_0000;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            wptr_q     <= wptr_d;
            fptr_q     <= fptr_d;
            rptr_q     <= rptr_d;
            drop_q     <= drop_d;
            if (req_fire_s) begin
                pc_q[wptr_q[AW-1:0]] <= fetch_pc_q;
            end
            if (rsp_fill_s && !i_ifq_redirect) begin
                instr_q[fptr_q[AW-1:0]] <= i_ifq_imem_rsp_data;
            end
        end
    end

    assign o_ifq_imem_req_valid = req_valid_s;
    assign o_ifq_imem_req_addr  = fetch_pc_q;
    assign o_ifq_id_valid       = id_valid_s;
    assign o_ifq_id_pc          = id_pc_s;
    assign o_ifq_id_instr       = id_instr_s;
    assign o_ifq_count          = count_s;

endmodule

// File: tb/tb_rv_if_fetch_queue.sv
// Directed bench for rv_if_fetch_queue (DEPTH=4): per-cycle vector table plus hand sequences.
module tb_rv_if_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        redir;
    logic [31:0] redir_pc;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_ready;
    logic [2:0]  count;

    int n_tests = 0;
    int n_fail  = 0;
    int step    = 0;

    always #5 clk = ~clk;

    rv_if_fetch_queue #(.XLEN(32), .DEPTH(4), .INIT_PC(32'h0000_0000)) dut (
        .i_ifq_clk            (clk),
        .i_ifq_rst            (rst),
        .i_ifq_redirect       (redir),
        .i_ifq_redirect_pc    (redir_pc),
        .o_ifq_imem_req_valid (req_valid),
        .o_ifq_imem_req_addr  (req_addr),
        .i_ifq_imem_req_ready (req_ready),
        .i_ifq_imem_rsp_valid (rsp_valid),
        .i_ifq_imem_rsp_data  (rsp_data),
        .o_ifq_id_valid       (id_valid),
        .o_ifq_id_pc          (id_pc),
        .o_ifq_id_instr       (id_instr),
        .i_ifq_id_ready       (id_ready),
        .o_ifq_count          (count)
    );

    typedef struct {
        logic        rst;
        logic        redir;
        logic [31:0] rpc;
        logic        rq_rdy;
        logic        rsp_v;
        logic [31:0] rsp_d;
        logic        id_rdy;
        logic        e_rqv;
        logic [31:0] e_addr;
        logic        e_idv;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] ins(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL step %0d %s: got %h expected %h", step, name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; redir = 1'b0; redir_pc = 32'h0; req_ready = 1'b0;
        rsp_valid = 1'b0; rsp_data = 32'h0; id_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One cycle: drive inputs after the edge, check outputs at the falling edge.
    task automatic cyc(input logic r, input logic [31:0] rpc, input logic rq, input logic rv,
                       input logic [31:0] rd, input logic ir, input logic e_rqv,
                       input logic [31:0] e_addr, input logic e_idv, input logic [31:0] e_pc,
                       input logic [31:0] e_ins, input logic [2:0] e_cnt);
        step++;
        redir = r; redir_pc = rpc; req_ready = rq; rsp_valid = rv; rsp_data = rd; id_ready = ir;
        @(negedge clk);
        chk("req_valid", {31'h0, req_valid}, {31'h0, e_rqv});
        if (e_rqv) chk("req_addr", req_addr, e_addr);
        chk("id_valid", {31'h0, id_valid}, {31'h0, e_idv});
        if (e_idv) begin
            chk("id_pc", id_pc, e_pc);
            chk("id_instr", id_instr, e_ins);
        end
        chk("count", {29'h0, count}, {29'h0, e_cnt});
        @(posedge clk);
        #1;
    endtask

    initial begin
        do_reset();
`ifndef RV_IFQ_BYPASS_EN
        // Streaming, 1-cycle latency, ID always ready.
        vecs.push_back('{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 3'd0});
        vecs.push_back('{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 3'd0});
        vecs.push_back('{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, ins(32'h0), 1'b1, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0, 3'd1});
        vecs.push_back('{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, ins(32'h4), 1'b1, 1'b1, 32'h8, 1'b1, 32'h0, ins(32'h0), 3'd2});
        vecs.push_back('{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, ins(32'h8), 1'b1, 1'b1, 32'hC, 1'b1, 32'h4, ins(32'h4), 3'd2});
        vecs.push_back('{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, ins(32'hC), 1'b1, 1'b1, 32'h10, 1'b1, 32'h8, ins(32'h8), 3'd2});
        vecs.push_back('{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 1'b1, 32'hC, ins(32'hC), 3'd1});
        vecs.push_back('{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 3'd0});
        // ID stalled: fill to DEPTH, then drain in order.
        vecs.push_back('{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 3'd0});
        vecs.push_back('{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 3'd0});
        vecs.push_back('{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, ins(32'h0), 1'b0, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0, 3'd1});
        vecs.push_back('{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, ins(32'h4), 1'b0, 1'b1, 32'h8, 1'b1, 32'h0, ins(32'h0), 3'd2});
        vecs.push_back('{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, ins(32'h8), 1'b0, 1'b1, 32'hC, 1'b1, 32'h0, ins(32'h0), 3'd3});
        vecs.push_back('{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, ins(32'hC), 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, ins(32'h0), 3'd4});
        vecs.push_back('{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, ins(32'h0), 3'd4});
        vecs.push_back('{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0, ins(32'h0), 3'd4});
        vecs.push_back('{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h4, ins(32'h4), 3'd3});
        vecs.push_back('{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8, ins(32'h8), 3'd2});
        vecs.push_back('{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 1'b1, 32'hC, ins(32'hC), 3'd1});
        vecs.push_back('{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 3'd0});

        foreach (vecs[i]) begin
            if (vecs[i].rst) begin
                do_reset();
            end else begin
                cyc(vecs[i].redir, vecs[i].rpc, vecs[i].rq_rdy, vecs[i].rsp_v, vecs[i].rsp_d,
                    vecs[i].id_rdy, vecs[i].e_rqv, vecs[i].e_addr, vecs[i].e_idv, vecs[i].e_pc,
                    vecs[i].e_ins, vecs[i].e_cnt);
            end
        end
`endif

        // Reset state after storage has held data: outputs must read back as zero.
        do_reset();
        step++;
        @(negedge clk);
        chk("rst_req_valid", {31'h0, req_valid}, 32'h1);
        chk("rst_req_addr", req_addr, 32'h0);
        chk("rst_id_valid", {31'h0, id_valid}, 32'h0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_instr", id_instr, 32'h0);
        chk("rst_count", {29'h0, count}, 32'h0);
        @(posedge clk);
        #1;

`ifndef RV_IFQ_BYPASS_EN
        // Redirect with three requests outstanding; three stale responses are dropped.
        do_reset();
        cyc(1'b0, 32'h0,   1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,   1'b0, 32'h0,   32'h0,       3'd0);
        cyc(1'b0, 32'h0,   1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4,   1'b0, 32'h0,   32'h0,       3'd1);
        cyc(1'b0, 32'h0,   1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h8,   1'b0, 32'h0,   32'h0,       3'd2);
        cyc(1'b1, 32'h100, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,       3'd3);
        cyc(1'b0, 32'h0,   1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h100, 1'b0, 32'h0,   32'h0,       3'd0);
        cyc(1'b0, 32'h0,   1'b1, 1'b1, 32'hBAD0_0000, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0,   32'h0,       3'd1);
        cyc(1'b0, 32'h0,   1'b1, 1'b1, 32'hBAD0_0001, 1'b1, 1'b1, 32'h104, 1'b0, 32'h0,  32'h0,       3'd1);
        cyc(1'b0, 32'h0,   1'b1, 1'b1, 32'hBAD0_0002, 1'b1, 1'b1, 32'h108, 1'b0, 32'h0,  32'h0,       3'd2);
        cyc(1'b0, 32'h0,   1'b1, 1'b1, ins(32'h100), 1'b1, 1'b1, 32'h10C, 1'b0, 32'h0,   32'h0,       3'd3);
        cyc(1'b0, 32'h0,   1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,   1'b1, 32'h100, ins(32'h100), 3'd4);
        cyc(1'b0, 32'h0,   1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h110, 1'b0, 32'h0,   32'h0,       3'd3);

        // Redirect concurrent with a response and req_ready; then redirect with a filled entry.
        do_reset();
        cyc(1'b0, 32'h0,   1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0,   1'b0, 32'h0,   32'h0,       3'd0);
        cyc(1'b0, 32'h0,   1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4,   1'b0, 32'h0,   32'h0,       3'd1);
        cyc(1'b1, 32'h200, 1'b1, 1'b1, ins(32'h0),   1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,       3'd2);
        cyc(1'b0, 32'h0,   1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h200, 1'b0, 32'h0,   32'h0,       3'd0);
        cyc(1'b0, 32'h0,   1'b1, 1'b1, 32'hBAD0_0003, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0,  32'h0,       3'd0);
        cyc(1'b0, 32'h0,   1'b1, 1'b1, ins(32'h200), 1'b1, 1'b1, 32'h204, 1'b0, 32'h0,   32'h0,       3'd1);
        cyc(1'b0, 32'h0,   1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h208, 1'b1, 32'h200, ins(32'h200), 3'd2);
        cyc(1'b0, 32'h0,   1'b0, 1'b1, ins(32'h204), 1'b0, 1'b1, 32'h208, 1'b0, 32'h0,   32'h0,       3'd1);
        cyc(1'b1, 32'h300, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,       3'd1);
        cyc(1'b0, 32'h0,   1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h300, 1'b0, 32'h0,   32'h0,       3'd0);

        // Fetch PC wrap at the top of the address space, then a spurious response.
        do_reset();
        cyc(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 3'd0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0, 3'd0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 3'd1);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, ins(32'hFFFF_FFFC), 1'b1, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0, 3'd2);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, ins(32'h0), 1'b1, 1'b1, 32'h4, 1'b1, 32'hFFFF_FFFC,
            ins(32'hFFFF_FFFC), 3'd2);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 1'b1, 32'h0, ins(32'h0), 3'd1);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'hBAD0_0004, 1'b1, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0, 3'd0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0, 3'd0);
`else
        // Same-cycle bypass of a response into an empty queue.
        do_reset();
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 3'd0);
        cyc(1'b0, 32'h0, 1'b0, 1'b1, ins(32'h0), 1'b1, 1'b1, 32'h4, 1'b1, 32'h0, ins(32'h0), 3'd1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0, 3'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
